strobe_coalescer: RTL
=====================

Name: strobe_coalescer

Overview:
- Sits directly downstream of the clock-domain strobe synchroniser, in the destination clock domain.
- Accumulates single-cycle event strobes into a pending-event count and exposes an acknowledge handshake to the consumer.
- Raises a coalesced interrupt when the count reaches a threshold or when a hold-off timer expires, so the host is not interrupted once per coax event.

Parameters:
- COUNT_WIDTH, 8, width of pending-event counter; saturates at 2^COUNT_WIDTH-1.
- TIMEOUT_WIDTH, 16, width of hold-off timer and timeout input.

Ports:
- clk  input  1  single clock for all logic.
- reset_n  input  1  asynchronous, active-low reset.
- strobe  input  1  one-cycle event pulse from the synchroniser; may be asserted on consecutive cycles.
- ack  input  1  consumer retires one pending event.
- clear_overflow  input  1  clears the sticky overflow flag.
- threshold  input  COUNT_WIDTH  count at which irq fires immediately; compared live every cycle.
- timeout  input  TIMEOUT_WIDTH  hold-off cycles; sampled on entry to WAIT.
- count  output  COUNT_WIDTH  registered pending-event count.
- pending  output  1  registered, high when count != 0.
- irq  output  1  registered level interrupt.
- overflow  output  1  registered sticky flag: a strobe was lost at saturation.

Behaviour:
- Reset (async assert, sync release): count=0, pending=0, irq=0, overflow=0, state=IDLE, timer=0. Asserting reset mid-operation discards everything immediately.
- Counter, evaluated each edge against the registered count:
  - strobe only: count+1.
  - ack only with count>0: count-1.
  - ack with count==0: ignored.
  - strobe+ack with count>0: unchanged.
  - strobe+ack with count==0: count becomes 1 (ack ignored).
- Saturation:
  - strobe without an effective ack at count==max: count holds at max, overflow<=1.
  - strobe+ack at max: unchanged, no overflow.
- Overflow clearing: clear_overflow clears overflow. If a clear and an overflow-setting strobe occur in the same cycle, set wins.
- pending tracks the next-state count, so it changes on the same edge as count.
- State machine (IDLE, WAIT, FIRE); transitions use the registered count:
  - IDLE: on the edge where count goes 0 -> nonzero, go to WAIT and load timer<=timeout.
  - WAIT, evaluated in this priority order:
    - count==0: go to IDLE, irq stays 0 (events retired before an interrupt was needed).
    - count>=threshold or timer==0: go to FIRE, irq<=1.
    - otherwise: timer<=timer-1.
  - FIRE: irq held at 1 until registered count==0, then irq<=0 and go to IDLE on the same edge. New strobes in FIRE do not restart the timer.
- Latency:
  - irq rises 1 cycle after count>=threshold becomes visible.
  - With timer expiry and no threshold hit, irq rises timeout+1 cycles after count first becomes nonzero.
- Boundary values:
  - threshold=0 or 1: fires one cycle after entering WAIT.
  - timeout=0: fires one cycle after entering WAIT.
  - Changing timeout during WAIT has no effect until the next entry to WAIT.
- No combinational path from any input to any output.

Test Plan:
- Reset, then single strobe with threshold=4, timeout=10 -> count=1 and pending=1 on the next edge; irq rises exactly 11 cycles later. One ack -> count=0, irq falls on the following edge, state=IDLE.
- Four back-to-back strobes with threshold=4, timeout=100 -> count reaches 4; irq rises 1 cycle later, well before the timer expires. Four acks -> irq drops after count=0.
- Strobe plus ack in the same cycle:
  - at count=0 -> count=1.
  - at count=3 -> count stays 3.
  - ack alone at count=0 -> count stays 0, no underflow.
- COUNT_WIDTH=3, nine strobes with no ack -> count saturates at 7 and overflow=1. Next, clear_overflow together with a strobe -> overflow stays 1. clear_overflow alone -> overflow=0.
- Strobe with timeout=20, ack after 5 cycles -> count=0, WAIT -> IDLE, irq never asserted. Repeat with threshold=1, timeout=0 -> irq rises 1 cycle after count=1.
- Drive reset_n low asynchronously between edges while in FIRE with count=5 and overflow=1 -> all outputs read 0 before the next clk edge. After release, the first strobe behaves as in scenario 1.

Source files
------------

// File: rtl/strobe_coalescer.sv
// Strobe coalescer: counts single-cycle event strobes from the synchroniser,
// lets the consumer retire them one at a time with ack, and raises a level
// interrupt when enough events are pending or a hold-off timer runs out.
//
// Handshake semantics: strobe and ack are single-cycle qualifiers with no
// backpressure. A strobe adds one event. An ack retires one event only when
// the registered count is non-zero. An ack at count 0 has no effect, and an
// ack in the same cycle as a strobe at count 0 is also ignored. Every output
// is a flop, so there is no input-to-output combinational path.
module strobe_coalescer #(
    parameter int COUNT_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     strobe,
    input  logic                     ack,
    input  logic                     clear_overflow,
    input  logic [COUNT_WIDTH-1:0]   threshold,
    input  logic [TIMEOUT_WIDTH-1:0] timeout,
    output logic [COUNT_WIDTH-1:0]   count,
    output logic                     pending,
    output logic                     irq,
    output logic                     overflow,
    output logic [1:0]               o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIRE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]   C_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0]   C_ONE = COUNT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] T_ONE = TIMEOUT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0]   r_count;
    logic                     r_pending;
    logic                     r_irq;
    logic                     r_overflow;
    state_t                   r_state;
    logic [TIMEOUT_WIDTH-1:0] r_timer;

    logic                     w_count_zero;
    logic                     w_count_max;
    logic                     w_eff_ack;
    logic                     w_ovf_set;
    logic [COUNT_WIDTH-1:0]   w_count_next;
    state_t                   w_state_next;
    logic [TIMEOUT_WIDTH-1:0] w_timer_next;
    logic                     w_irq_next;

    assign w_count_zero = (r_count == '0);
    assign w_count_max  = (r_count == C_MAX);
    // An ack only counts when there is something to retire.
    assign w_eff_ack    = ack & ~w_count_zero;
    // A strobe that cannot be absorbed at saturation is a lost event.
    assign w_ovf_set    = strobe & ~w_eff_ack & w_count_max;

    // Next pending count: +1 on a lone strobe (saturating), -1 on a lone effective ack.
    always_comb begin
        w_count_next = r_count;
        if (strobe && !w_eff_ack) begin
            if (!w_count_max) begin
                w_count_next = r_count + C_ONE;
            end
        end else if (!strobe && w_eff_ack) begin
            w_count_next = r_count - C_ONE;
        end
    end

    // Counter, pending flag and sticky overflow; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_pending <= (w_count_next != '0);
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Interrupt FSM next-state: IDLE arms on the first event, WAIT counts down the
    // hold-off or fires early on threshold, FIRE holds irq until all events retire.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_irq_next   = r_irq;
        case (r_state)
            ST_IDLE: begin
                if (w_count_next != '0) begin
                    w_state_next = ST_WAIT;
                    w_timer_next = timeout;
                end
            end
            ST_WAIT: begin
                if (w_count_zero) begin
                    w_state_next = ST_IDLE;
                end else if ((r_count >= threshold) || (r_timer == '0)) begin
                    w_state_next = ST_FIRE;
                    w_irq_next   = 1'b1;
                end else begin
                    w_timer_next = r_timer - T_ONE;
                end
            end
            ST_FIRE: begin
                if (w_count_zero) begin
                    w_state_next = ST_IDLE;
                    w_irq_next   = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_irq_next   = 1'b0;
            end
        endcase
    end

    // FSM state, hold-off timer and registered interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_irq   <= w_irq_next;
        end
    end

    assign count    = r_count;
    assign pending  = r_pending;
    assign irq      = r_irq;
    assign overflow = r_overflow;
    assign o_state  = r_state;

endmodule
